// File: rtl/bus_arbiter_2r_if.sv
// Request/grant and bus-mux control bundle between two bus masters and the
// two-requester bus arbiter.
interface bus_arbiter_2r_if;
  logic       req1;
  logic       req2;
  logic       ack1;
  logic       ack2;
  logic [1:0] bus_select;
  logic       bus_switch;
  logic       preempt;

  // Arbiter side: consumes requests, drives grants and bus-mux controls.
  modport master (
    input  req1,
    input  req2,
    output ack1,
    output ack2,
    output bus_select,
    output bus_switch,
    output preempt
  );

  // Requester side: drives requests, observes grants and bus-mux controls.
  modport slave (
    output req1,
    output req2,
    input  ack1,
    input  ack2,
    input  bus_select,
    input  bus_switch,
    input  preempt
  );
endinterface

// File: rtl/bus_arbiter_2r.sv
// Two-requester round-robin bus arbiter with bounded tenure, forced preemption
// and a fixed-length turnaround window between successive bus owners.
module bus_arbiter_2r #(
  parameter int unsigned MAX_HOLD   = 32'd16,
  parameter int unsigned SWITCH_CYC = 32'd2
) (
  input logic              clk,
  input logic              rst_n,
  bus_arbiter_2r_if.master bus
);
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD);
  localparam int unsigned SW_W   = $clog2(SWITCH_CYC + 32'd1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 32'd1);
  localparam logic [SW_W-1:0]   SW_LAST   = SW_W'(SWITCH_CYC - 32'd1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT1 = 2'd1;
  localparam logic [1:0] ST_GRANT2 = 2'd2;
  localparam logic [1:0] ST_SWITCH = 2'd3;

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [SW_W-1:0]   sw_cnt_r;
  logic              last_grant_r;   // 1'b1: requester 2 owned the bus last
  logic              pick_any_s;
  logic              pick2_s;
  logic              preempt_nxt_s;
  logic              ack1_r;
  logic              ack2_r;
  logic [1:0]        bus_select_r;
  logic              bus_switch_r;
  logic              preempt_r;

  // Round-robin winner: a lone requester wins, a tie goes to the non-last owner.
  always_comb begin
    pick_any_s = bus.req1 | bus.req2;
    if (bus.req1 && bus.req2) begin
      pick2_s = ~last_grant_r;
    end else begin
      pick2_s = bus.req2;
    end
  end

  // Next-state decode; every release goes through the turnaround window.
  always_comb begin
    state_nxt_s   = state_r;
    preempt_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_nxt_s = pick2_s ? ST_GRANT2 : ST_GRANT1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT1: begin
        if (!bus.req1) begin
          state_nxt_s = ST_SWITCH;
        end else if ((hold_cnt_r == HOLD_LAST) && bus.req2) begin
          state_nxt_s   = ST_SWITCH;
          preempt_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_GRANT1;
        end
      end
      ST_GRANT2: begin
        if (!bus.req2) begin
          state_nxt_s = ST_SWITCH;
        end else if ((hold_cnt_r == HOLD_LAST) && bus.req1) begin
          state_nxt_s   = ST_SWITCH;
          preempt_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_GRANT2;
        end
      end
      ST_SWITCH: begin
        // Requests only matter on the last turnaround cycle.
        if (sw_cnt_r != SW_LAST) begin
          state_nxt_s = ST_SWITCH;
        end else if (pick_any_s) begin
          state_nxt_s = pick2_s ? ST_GRANT2 : ST_GRANT1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, tenure/turnaround counters, fairness history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      hold_cnt_r   <= {HOLD_W{1'b0}};
      sw_cnt_r     <= {SW_W{1'b0}};
      last_grant_r <= 1'b1;
      ack1_r       <= 1'b0;
      ack2_r       <= 1'b0;
      bus_select_r <= 2'b00;
      bus_switch_r <= 1'b0;
      preempt_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;

      // Tenure counter saturates so an uncontested owner keeps the bus.
      if (((state_nxt_s == ST_GRANT1) || (state_nxt_s == ST_GRANT2)) &&
          (state_nxt_s == state_r)) begin
        if (hold_cnt_r != HOLD_LAST) begin
          hold_cnt_r <= hold_cnt_r + HOLD_W'(32'd1);
        end else begin
          hold_cnt_r <= hold_cnt_r;
        end
      end else begin
        hold_cnt_r <= {HOLD_W{1'b0}};
      end

      if ((state_nxt_s == ST_SWITCH) && (state_r == ST_SWITCH)) begin
        sw_cnt_r <= sw_cnt_r + SW_W'(32'd1);
      end else begin
        sw_cnt_r <= {SW_W{1'b0}};
      end

      if ((state_nxt_s == ST_GRANT1) && (state_r != ST_GRANT1)) begin
        last_grant_r <= 1'b0;
      end else if ((state_nxt_s == ST_GRANT2) && (state_r != ST_GRANT2)) begin
        last_grant_r <= 1'b1;
      end else begin
        last_grant_r <= last_grant_r;
      end

      ack1_r       <= (state_nxt_s == ST_GRANT1);
      ack2_r       <= (state_nxt_s == ST_GRANT2);
      bus_switch_r <= (state_nxt_s == ST_SWITCH);
      preempt_r    <= preempt_nxt_s;
      case (state_nxt_s)
        ST_GRANT1: bus_select_r <= 2'b01;
        ST_GRANT2: bus_select_r <= 2'b10;
        default:   bus_select_r <= 2'b00;
      endcase
    end
  end

  assign bus.ack1       = ack1_r;
  assign bus.ack2       = ack2_r;
  assign bus.bus_select = bus_select_r;
  assign bus.bus_switch = bus_switch_r;
  assign bus.preempt    = preempt_r;
endmodule

// File: doc/bus_arbiter_2r.md
Name: bus_arbiter_2r

Overview:
- Two-requester bus arbiter that owns the shared-bus controls `bus_select` and `bus_switch`, and answers `req1`/`req2` with `ack1`/`ack2`.
- Round-robin fairness, a bounded grant tenure with forced preemption, and a programmable turnaround window (`bus_switch` high) between owners.
- Sits between the two bus masters and the bus mux; its outputs feed the `ap_active_bus`-style property checks.

Parameters:
- MAX_HOLD, 16, max grant cycles while the other requester waits; range 2..255.
- SWITCH_CYC, 2, turnaround cycles between owners; range 1..15.

Ports:
- clk  input  1  bus clock; all state on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req1  input  1  requester 1 bus request; level, held for the whole tenure.
- req2  input  1  requester 2 bus request; level, held for the whole tenure.
- ack1  output  1  registered grant to requester 1.
- ack2  output  1  registered grant to requester 2.
- bus_select  output  2  current owner: 2'b00 none, 2'b01 req1, 2'b10 req2; 2'b11 never driven.
- bus_switch  output  1  high during turnaround; bus mux disabled.
- preempt  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - ack1=0, ack2=0, bus_select=00, bus_switch=0, preempt=0.
  - hold_cnt=0, sw_cnt=0, last_grant=2 (requester 1 wins the first tie).
- All outputs are registered, decoded from state:
  - GRANT1: ack1=1, bus_select=01.
  - GRANT2: ack2=1, bus_select=10.
  - SWITCH: bus_switch=1, bus_select=00.
- Invariant: ack1 & ack2 never both high; bus_switch=1 implies both acks 0.
- States: IDLE, GRANT1, GRANT2, SWITCH.
- Winner selection (IDLE, and at SWITCH exit):
  - Only one requester active: that one wins.
  - Both active: the one not equal to last_grant wins.
  - last_grant updates on entry to GRANTx.
- IDLE:
  - Any request sampled at edge k → GRANTx after edge k (ack visible the cycle after the request is seen; 1-cycle latency).
  - No request → stay in IDLE.
- GRANTx:
  - hold_cnt clears on entry and increments each cycle.
  - Saturates at MAX_HOLD-1 while the other requester is idle; the grant then continues indefinitely.
  - Own req low sampled → SWITCH. No preempt.
  - Own req high, hold_cnt==MAX_HOLD-1 and other req high → SWITCH, with preempt=1 for exactly that cycle.
  - Own req dropping in the same cycle as the preempt condition counts as a normal release: no preempt.
- SWITCH:
  - Lasts exactly SWITCH_CYC cycles; sw_cnt counts 0..SWITCH_CYC-1.
  - Requests are not sampled until the final SWITCH cycle.
  - Winner selection is evaluated on the final cycle → GRANTx, or IDLE if no request.
  - A request dropped mid-switch is simply not granted.
  - The preempted requester keeping req high is eligible again, but loses the tie.
- Every release passes through SWITCH, including release to IDLE. There is no direct GRANT1↔GRANT2 transition.
- Request glitches while not granted have no effect except at sample points.
- Counters are unsigned, width $clog2(MAX_HOLD) and $clog2(SWITCH_CYC+1), with no wrap.
- rst_n asserted mid-tenure: acks drop immediately (asynchronously); first grant after deassertion follows IDLE rules.

Test Plan:
- Reset then req1=1 at cycle 3 → ack1=1, bus_select=01 from cycle 4; bus_switch=0.
- req1 and req2 rise together after reset → ack1 first. req1 drops → bus_switch=1 for 2 cycles (bus_select=00), then ack2=1, bus_select=10.
- req1 held, req2 held, MAX_HOLD=16 → ack1 for exactly 16 cycles; preempt pulses once; 2 turnaround cycles; ack2. req1 still high → ack1 returns after ack2's tenure.
- req1 alone held for 100 cycles → ack1 stays high throughout; preempt never asserts.
- req2 granted, req2 drops, req1 rises on the 1st SWITCH cycle and drops on the 2nd → state IDLE, no ack. With req1 held instead → ack1 after SWITCH.
- rst_n pulsed low during GRANT2 → ack2, bus_select clear without a clock edge. After release with both requesting → ack1 wins.
- Throughout all scenarios: assertions that ack1&ack2 never both high, bus_select!=11, and bus_switch→!ack1&&!ack2.
